dcache_direct: RTL and testbench
================================

Name: dcache_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and bram_controller.
- Serves single-word CPU loads and stores in one cycle on a hit.
- On a miss it writes back the dirty victim line as one block operation, then refills the line as one block read.
- Line geometry matches the controller's block: 8 lines × 32 words, with address fields [tag 8 | index 3 | offset 5].

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 16, word address width (1 word per address).
- INDEX_WIDTH, 3, line index bits; 2^INDEX_WIDTH lines.
- BLOCK_OFFSET_WIDTH, 5, word-in-line bits; must equal the controller's value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid while cpu_ready is high.
- cpu_ready  out  1  access completes this cycle.
- mem_addr  out  ADDR_WIDTH  block base address (offset = 0), held stable for the whole operation.
- mem_req_op  out  1  single-cycle start pulse.
- mem_rw  out  1  `MEM_WRITE / `MEM_READ.
- mem_data_write  out  DATA_WIDTH  write-back word.
- mem_data_write_req_input  in  1  controller is consuming write-back words.
- mem_data_read  in  DATA_WIDTH  refill word.
- mem_data_read_valid  in  1  mem_data_read holds the next refill word.
- mem_finished  in  1  one-cycle end-of-block pulse.

Behaviour:
- Reset (async, rst=1):
  - All valid and dirty bits cleared; data and tag arrays are not reset.
  - state=IDLE; mem_req_op=0, mem_rw=`MEM_READ, mem_addr=0.
  - cpu_ready=0, wb_cnt=0, fill_cnt=0.
- Hit (IDLE, cpu_req, valid[idx], tag match):
  - cpu_ready=1 combinationally in the same cycle; cpu_rdata=data[idx][off].
  - A store writes the word and sets dirty[idx] at the clock edge.
- Miss: cpu_ready=0.
  - If valid and dirty → WB_REQ, else → FILL_REQ.
- WB_REQ (1 cycle):
  - mem_req_op=1, mem_rw=`MEM_WRITE, mem_addr={old_tag, idx, 0}, wb_cnt←0; → WB_WAIT.
- WB_WAIT:
  - mem_data_write = data[idx][wb_cnt + mem_data_write_req_input], with the sum truncated to BLOCK_OFFSET_WIDTH.
  - wb_cnt increments on every edge where mem_data_write_req_input=1.
  - On mem_finished: clear dirty[idx]; → FILL_REQ.
- FILL_REQ (1 cycle):
  - mem_req_op=1, mem_rw=`MEM_READ, mem_addr={cpu_tag, idx, 0}, fill_cnt←0; → FILL_WAIT.
- FILL_WAIT:
  - Each cycle with mem_data_read_valid=1 and fill_cnt<BLOCK_SIZE: data[idx][fill_cnt]←mem_data_read, fill_cnt++ (counter is BLOCK_OFFSET_WIDTH+1 bits).
  - Valid beats after 32 words are ignored; the controller holds valid for one extra cycle.
  - On mem_finished: tag[idx]←cpu_tag, valid[idx]←1, dirty[idx]←0; → IDLE.
  - The access then re-evaluates as a hit on the next cycle, so the miss penalty is fixed and store-after-allocate is an ordinary hit.
- mem_req_op is never high outside WB_REQ/FILL_REQ. This guarantees the controller does not restart when it returns to READY.
- cpu_req deasserted mid-miss: the operation in flight completes and the line is filled; no CPU response.
- mem_finished is ignored in IDLE.
- rst mid-operation: immediate return to IDLE with lines invalidated. The controller shares the system reset, so no partial block survives.

Optional Feature:
- DCACHE_PERF_EN defined:
  - Adds outputs hit_count and miss_count, 32 bits each, reset to 0, saturating at all-ones.
  - hit_count increments on each cycle with cpu_ready=1 that was not the first cycle after a refill.
  - miss_count increments on each IDLE→WB_REQ/FILL_REQ transition.
- Not defined: no ports and no logic.

Decomposition:
- defines.v holds MEM_READ/MEM_WRITE, state encodings (IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT), and derived constants BLOCK_SIZE and TAG_WIDTH=ADDR_WIDTH-INDEX_WIDTH-BLOCK_OFFSET_WIDTH.
- One sub-module, dcache_tag_array: valid/dirty/tag storage with async clear; combinational lookup returning hit and victim_dirty.

Test Plan:
- Cold load of 0x1234 after reset → FILL_REQ with mem_addr=0x1220; 32 words from a model with word n = 0xA000+n; cpu_ready on the cycle after mem_finished; cpu_rdata=0xA014.
- Load 0x1235 right after → hit in 1 cycle, cpu_rdata=0xA015, no mem_req_op.
- Store 0xDEADBEEF to 0x1235, then load 0x2234 (same index) → write-back at mem_addr=0x1220 with word 21=0xDEADBEEF and words 0..31 in order; then fill at 0x2220.
- Refill with mem_data_read_valid held 33 cycles (extra beat 0xFFFFFFFF) → word 0 unchanged, all 32 words match the model.
- rst pulsed during FILL_WAIT at beat 10 → all outputs return to reset values; reloading 0x1234 misses again.
- DCACHE_PERF_EN defined, scenarios 1–3 → miss_count=2, hit_count=2.

Source files
------------

// File: rtl/dcache_direct_pkg.sv
// dcache_direct_pkg: cache geometry, memory op codes, FSM state encoding
package dcache_direct_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int INDEX_WIDTH = 3;
  localparam int BLOCK_OFFSET_WIDTH = 5;
  localparam int BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam int NUM_LINES = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  typedef logic [BLOCK_OFFSET_WIDTH-1:0] off_t;
  typedef logic [BLOCK_OFFSET_WIDTH:0] fcnt_t;
  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;
endpackage

// File: rtl/dcache_direct_if.sv
// dcache_direct_if: CPU-side and bram_controller-side signals of the cache
// slave = cache side, master = CPU plus controller side
interface dcache_direct_if;
  import dcache_direct_pkg::*;
  logic cpu_req;
  logic cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic cpu_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_req_op;
  logic mem_rw;
  logic [DATA_WIDTH-1:0] mem_data_write;
  logic mem_data_write_req_input;
  logic [DATA_WIDTH-1:0] mem_data_read;
  logic mem_data_read_valid;
  logic mem_finished;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input mem_data_write_req_input, mem_data_read, mem_data_read_valid, mem_finished,
    output cpu_rdata, cpu_ready, mem_addr, mem_req_op, mem_rw, mem_data_write
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_data_write_req_input, mem_data_read, mem_data_read_valid, mem_finished,
    input cpu_rdata, cpu_ready, mem_addr, mem_req_op, mem_rw, mem_data_write
  );
endinterface

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: valid/dirty/tag storage with async clear and combinational lookup
// ports: clk, rst; i_idx/i_tag lookup+update address; i_set_dirty, i_clr_dirty, i_fill updates;
// o_hit, o_victim_dirty, o_victim_tag lookup results
module dcache_tag_array
  import dcache_direct_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  idx_t i_idx,
  input  tag_t i_tag,
  input  logic i_set_dirty,
  input  logic i_clr_dirty,
  input  logic i_fill,
  output logic o_hit,
  output logic o_victim_dirty,
  output tag_t o_victim_tag
);
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  tag_t r_tag [NUM_LINES];
  assign o_victim_tag = r_tag[i_idx];
  assign o_hit = r_valid[i_idx] && r_tag[i_idx] == i_tag;
  assign o_victim_dirty = r_valid[i_idx] && r_dirty[i_idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill) r_valid[i_idx] <= 1'b1;
      if (i_set_dirty) r_dirty[i_idx] <= 1'b1;
      if (i_fill || i_clr_dirty) r_dirty[i_idx] <= 1'b0;
    end
  end
  always_ff @(posedge clk) if (i_fill) r_tag[i_idx] <= i_tag;
endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped write-back write-allocate data cache in front of bram_controller
// ports: clk, rst (async, active-high); bus (dcache_direct_if.slave) carries CPU and controller signals;
// optional DCACHE_PERF_EN adds o_hit_count, o_miss_count saturating counters
module dcache_direct
  import dcache_direct_pkg::*;
(
  input  logic clk,
  input  logic rst,
  dcache_direct_if.slave bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);
  state_t r_state;
  idx_t r_idx;
  tag_t r_tag;
  off_t r_wb_cnt;
  fcnt_t r_fill_cnt;
  logic r_mem_req_op, r_mem_rw;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_data [NUM_LINES][BLOCK_SIZE];
  logic w_idle, w_hit, w_victim_dirty, w_miss, w_store, w_beat, w_fill_done, w_wb_done;
  tag_t w_tag, w_victim_tag;
  idx_t w_idx;
  off_t w_off, w_wb_off;
  assign w_tag = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_idx = bus.cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_off = bus.cpu_addr[BLOCK_OFFSET_WIDTH-1:0];
  assign w_idle = r_state == IDLE;
  assign w_miss = w_idle && bus.cpu_req && !w_hit;
  assign w_store = bus.cpu_ready && bus.cpu_we;
  // fill_cnt's top bit marks a full line; later valid beats are dropped
  assign w_beat = r_state == FILL_WAIT && bus.mem_data_read_valid && !r_fill_cnt[BLOCK_OFFSET_WIDTH];
  assign w_fill_done = r_state == FILL_WAIT && bus.mem_finished;
  assign w_wb_done = r_state == WB_WAIT && bus.mem_finished;
  // the controller latches the current word and asks for the next one, so present one word ahead
  assign w_wb_off = r_wb_cnt + off_t'(bus.mem_data_write_req_input);
  assign bus.cpu_ready = w_idle && bus.cpu_req && w_hit;
  assign bus.cpu_rdata = r_data[w_idx][w_off];
  assign bus.mem_data_write = r_data[r_idx][w_wb_off];
  assign bus.mem_req_op = r_mem_req_op;
  assign bus.mem_rw = r_mem_rw;
  assign bus.mem_addr = r_mem_addr;
  // lookups use the live CPU address; during a miss the latched line is used
  dcache_tag_array u_tags (
    .clk(clk),
    .rst(rst),
    .i_idx(w_idle ? w_idx : r_idx),
    .i_tag(w_idle ? w_tag : r_tag),
    .i_set_dirty(w_store),
    .i_clr_dirty(w_wb_done),
    .i_fill(w_fill_done),
    .o_hit(w_hit),
    .o_victim_dirty(w_victim_dirty),
    .o_victim_tag(w_victim_tag)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_tag <= '0;
      r_wb_cnt <= '0;
      r_fill_cnt <= '0;
      r_mem_req_op <= 1'b0;
      r_mem_rw <= MEM_READ;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_miss) begin
          r_idx <= w_idx;
          r_tag <= w_tag;
          r_mem_req_op <= 1'b1;
          r_state <= w_victim_dirty ? WB_REQ : FILL_REQ;
          r_mem_rw <= w_victim_dirty ? MEM_WRITE : MEM_READ;
          r_mem_addr <= {w_victim_dirty ? w_victim_tag : w_tag, w_idx, off_t'(0)};
        end
        WB_REQ: begin
          r_mem_req_op <= 1'b0;
          r_wb_cnt <= '0;
          r_state <= WB_WAIT;
        end
        WB_WAIT: begin
          if (bus.mem_data_write_req_input) r_wb_cnt <= r_wb_cnt + off_t'(1);
          if (bus.mem_finished) begin
            r_mem_req_op <= 1'b1;
            r_mem_rw <= MEM_READ;
            r_mem_addr <= {r_tag, r_idx, off_t'(0)};
            r_state <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          r_mem_req_op <= 1'b0;
          r_fill_cnt <= '0;
          r_state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (w_beat) r_fill_cnt <= r_fill_cnt + fcnt_t'(1);
          if (bus.mem_finished) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (w_beat) r_data[r_idx][r_fill_cnt[BLOCK_OFFSET_WIDTH-1:0]] <= bus.mem_data_read;
    if (w_store) r_data[w_idx][w_off] <= bus.cpu_wdata;
  end
`ifdef DCACHE_PERF_EN
  logic r_refilled;
  // the replayed hit right after a refill belongs to the miss, not the hit count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refilled <= 1'b0;
      o_hit_count <= '0;
      o_miss_count <= '0;
    end else begin
      r_refilled <= w_fill_done;
      if (bus.cpu_ready && !r_refilled && !(&o_hit_count)) o_hit_count <= o_hit_count + 32'd1;
      if (w_miss && !(&o_miss_count)) o_miss_count <= o_miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: directed self-checking bench for dcache_direct with a small controller model
module tb_dcache_direct;
  import dcache_direct_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_direct_if bus ();
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif
  dcache_direct dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DCACHE_PERF_EN
    ,
    .o_hit_count(hit_count),
    .o_miss_count(miss_count)
`endif
  );
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wb_words [BLOCK_SIZE];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_req;
    for (int i = 0; i < 20 && !bus.mem_req_op; i++) step;
    chk("req_seen", 32'(bus.mem_req_op), 32'd1);
  endtask
  task automatic fill(input logic [31:0] base, input logic extra);
    for (int n = 0; n < BLOCK_SIZE; n++) begin
      step;
      bus.mem_data_read_valid = 1'b1;
      bus.mem_data_read = base + 32'(n);
    end
    step;
    bus.mem_data_read = 32'hFFFF_FFFF;
    bus.mem_data_read_valid = extra;
    bus.mem_finished = 1'b1;
    step;
    bus.mem_data_read_valid = 1'b0;
    bus.mem_finished = 1'b0;
    bus.mem_data_read = '0;
    #1;
  endtask
  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.mem_data_write_req_input = 1'b0;
    bus.mem_data_read = '0;
    bus.mem_data_read_valid = 1'b0;
    bus.mem_finished = 1'b0;
    step;
    chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_req_op", 32'(bus.mem_req_op), 32'd0);
    chk("rst_rw", 32'(bus.mem_rw), 32'(MEM_READ));
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    step;
    rst = 1'b0;
    step;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 16'h1234;
    #1;
    chk("cold_miss_ready", 32'(bus.cpu_ready), 32'd0);
    wait_req;
    chk("cold_rw", 32'(bus.mem_rw), 32'(MEM_READ));
    chk("cold_addr", 32'(bus.mem_addr), 32'h1220);
    fill(32'hA000, 1'b0);
    chk("cold_ready", 32'(bus.cpu_ready), 32'd1);
    chk("cold_rdata", bus.cpu_rdata, 32'hA014);
    step;
    bus.cpu_addr = 16'h1235;
    #1;
    chk("hit_ready", 32'(bus.cpu_ready), 32'd1);
    chk("hit_rdata", bus.cpu_rdata, 32'hA015);
    chk("hit_no_req", 32'(bus.mem_req_op), 32'd0);
    step;
    bus.cpu_we = 1'b1;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("store_ready", 32'(bus.cpu_ready), 32'd1);
    step;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h2234;
    #1;
    chk("conflict_ready", 32'(bus.cpu_ready), 32'd0);
    wait_req;
    chk("wb_rw", 32'(bus.mem_rw), 32'(MEM_WRITE));
    chk("wb_addr", 32'(bus.mem_addr), 32'h1220);
    step;
    wb_words[0] = bus.mem_data_write;
    for (int k = 1; k < BLOCK_SIZE; k++) begin
      step;
      bus.mem_data_write_req_input = 1'b1;
      #1;
      wb_words[k] = bus.mem_data_write;
    end
    step;
    bus.mem_data_write_req_input = 1'b0;
    bus.mem_finished = 1'b1;
    step;
    bus.mem_finished = 1'b0;
    #1;
    for (int k = 0; k < BLOCK_SIZE; k++)
      chk($sformatf("wb_word%0d", k), wb_words[k], k == 21 ? 32'hDEAD_BEEF : 32'hA000 + 32'(k));
    wait_req;
    chk("fill2_rw", 32'(bus.mem_rw), 32'(MEM_READ));
    chk("fill2_addr", 32'(bus.mem_addr), 32'h2220);
    fill(32'hB000, 1'b1);
    chk("fill2_ready", 32'(bus.cpu_ready), 32'd1);
    chk("fill2_rdata", bus.cpu_rdata, 32'hB014);
`ifdef DCACHE_PERF_EN
    chk("perf_miss", miss_count, 32'd2);
    chk("perf_hit", hit_count, 32'd2);
`endif
    for (int n = 0; n < BLOCK_SIZE; n++) begin
      step;
      bus.cpu_addr = 16'h2220 + 16'(n);
      #1;
      chk($sformatf("line2_word%0d", n), bus.cpu_rdata, 32'hB000 + 32'(n));
    end
    step;
    bus.cpu_addr = 16'h3234;
    #1;
    chk("r_miss_ready", 32'(bus.cpu_ready), 32'd0);
    wait_req;
    chk("r_fill_addr", 32'(bus.mem_addr), 32'h3220);
    for (int n = 0; n < 10; n++) begin
      step;
      bus.mem_data_read_valid = 1'b1;
      bus.mem_data_read = 32'hC000 + 32'(n);
    end
    step;
    rst = 1'b1;
    bus.mem_data_read_valid = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.cpu_ready), 32'd0);
    chk("midrst_req_op", 32'(bus.mem_req_op), 32'd0);
    chk("midrst_rw", 32'(bus.mem_rw), 32'(MEM_READ));
    chk("midrst_addr", 32'(bus.mem_addr), 32'h0);
    step;
    rst = 1'b0;
    bus.cpu_addr = 16'h1234;
    #1;
    chk("reload_ready", 32'(bus.cpu_ready), 32'd0);
    wait_req;
    chk("reload_rw", 32'(bus.mem_rw), 32'(MEM_READ));
    chk("reload_addr", 32'(bus.mem_addr), 32'h1220);
    bus.cpu_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
